multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  run enable; level-sensitive, sampled in IDLE and WB.
REQ-005 SHALL have port Op_i  input  7  opcode field of the instruction register (instr[6:0]).
REQ-006 SHALL have port imem_ready_i  input  1  instruction memory data valid this cycle.
REQ-007 SHALL have port imem_req_o  output  1  fetch request to instruction memory.
REQ-008 SHALL have port IRWrite_o  output  1  load instruction register.
REQ-009 SHALL have port PCWrite_o  output  1  load PC with PC+4.
REQ-010 SHALL have port RegWrite_o  output  1  register-file write enable.
REQ-011 SHALL have port ALUSrc_o  output  1  0 = RS2 data, 1 = sign-extended immediate.
REQ-012 SHALL have port ALUOp_o  output  2  ALU class code to ALU_Control.
REQ-013 SHALL have port state_o  output  3  current state encoding.
REQ-014 SHALL have port illegal_o  output  1  sticky illegal-opcode flag.
REQ-015 SHALL have port retired_o  output  CNT_W  count of completed instructions.

Function
REQ-016 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6-7 unreachable, SHALL go to IDLE if entered.
REQ-017 IDLE: start_i=1 -> FETCH next cycle; else stay.
REQ-018 FETCH: imem_req_o=1 every cycle in state; stay while imem_ready_i=0; on imem_ready_i=1 assert IRWrite_o in that same cycle (the only input-dependent output) and go to DECODE.
REQ-019 DECODE: Op_i=7'b0110011 (R-type) latches class R; Op_i=7'b0010011 (I-type ALU) latches class I; both -> EXEC.
REQ-020 DECODE with any other Op_i -> HALT; illegal_o set at that edge; PC, register file and counter not written.
REQ-021 EXEC: one cycle, -> WB unconditionally.
REQ-022 WB: RegWrite_o=1 and PCWrite_o=1 for exactly this one cycle; retired_o increments at the WB exit edge; start_i=1 -> FETCH, start_i=0 -> IDLE.
REQ-023 ALUSrc_o/ALUOp_o SHALL be driven from the latched class in EXEC and WB: R -> 0/2'b10, I -> 1/2'b11; 0/2'b00 in all other states.
REQ-024 Every output except IRWrite_o SHALL be a function of registered state only; latency start_i rise to first RegWrite_o = 4 cycles with zero memory wait.
REQ-025 start_i deasserted mid-instruction SHALL NOT abort it; instruction completes through WB.
REQ-026 HALT: all strobes 0, state held until rst_i; start_i ignored.
REQ-027 retired_o SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-028 imem_ready_i outside FETCH SHALL be ignored.

Reset
REQ-029 rst_i=1 at a rising edge SHALL force state IDLE, class R, illegal_o=0, retired_o=0, all strobes 0, regardless of current state, including mid-FETCH wait and HALT.
REQ-030 rst_i SHALL take priority over every other input in the same cycle.

Structure
REQ-031 State encodings, opcode constants (7'b0110011, 7'b0010011) and ALUOp codes SHALL reside in shared package cpu_ctrl_pkg, also used by Control and ALU_Control.
REQ-032 Retire counter SHALL be sub-module retire_counter (CNT_W, clk_i, rst_i, inc_i, count_o); FSM and decode stay in multicycle_ctrl.

Verification
REQ-033 Reset, start_i=1, imem_ready_i=1, Op_i=7'b0110011 -> states 1,2,3,4; RegWrite_o=1 in WB only; ALUSrc_o=0, ALUOp_o=2'b10; retired_o=1.
REQ-034 Op_i=7'b0010011, imem_ready_i low 3 cycles in FETCH -> imem_req_o high 4 cycles, single IRWrite_o pulse, ALUSrc_o=1, ALUOp_o=2'b11 in EXEC/WB.
REQ-035 Op_i=7'b0000011 in DECODE -> HALT, illegal_o=1, no RegWrite_o/PCWrite_o, retired_o unchanged; start_i toggling has no effect; rst_i -> IDLE, illegal_o=0.
REQ-036 start_i dropped in EXEC -> WB completes, then IDLE; start_i held -> back-to-back instructions every 4 cycles, 10 instructions -> retired_o=10.
REQ-037 rst_i asserted in DECODE and in FETCH wait -> IDLE next cycle, all outputs 0; CNT_W=4 after 16 retirements -> retired_o=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multicycle CPU control path.
// Holds FSM state encodings, the two supported opcodes, the ALU class
// codes and the ALUOp lookup. Control and ALU_Control import this package
// as well, so these encodings must stay in lockstep across those blocks.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction class captured in DECODE, consumed in EXEC and WB.
  typedef enum logic {
    CLASS_R = 1'b0,
    CLASS_I = 1'b1
  } alu_class_t;

  localparam logic [OPC_W-1:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I_ALU  = 7'b0010011;

  localparam logic [ALUOP_W-1:0] ALUOP_NONE = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_R    = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_I    = 2'b11;

  // ALU class code presented to ALU_Control for a latched class.
  function automatic logic [ALUOP_W-1:0] alu_op_of(input alu_class_t c);
    return (c == CLASS_I) ? ALUOP_I : ALUOP_R;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch handshake between the controller and instruction memory.
//   imem_req_o   : controller -> memory, fetch request (high for all of FETCH)
//   imem_ready_i : memory -> controller, fetched data valid this cycle
//   Op_i         : opcode field instr[6:0] of the instruction register
//   IRWrite_o    : controller -> datapath, load instruction register
// Signal suffixes are from the controller's point of view.
interface multicycle_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic             imem_req_o;
  logic             imem_ready_i;
  logic             IRWrite_o;
  logic [OPC_W-1:0] Op_i;

  modport master (
    output imem_req_o,
    output IRWrite_o,
    input  imem_ready_i,
    input  Op_i
  );

  modport slave (
    input  imem_req_o,
    input  IRWrite_o,
    output imem_ready_i,
    output Op_i
  );

endinterface

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^CNT_W.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : count one retirement at this rising edge
//   count_o : current count (registered)
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= count_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB.
// Decodes R-type and I-type ALU opcodes; any other opcode halts the core
// with a sticky illegal flag until reset.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : run enable, sampled in IDLE and WB
//   imem         : fetch handshake (imem_req_o, imem_ready_i, Op_i, IRWrite_o)
//   PCWrite_o    : load PC with PC+4 (WB only)
//   RegWrite_o   : register-file write enable (WB only)
//   ALUSrc_o     : 0 = RS2, 1 = immediate
//   ALUOp_o      : ALU class code to ALU_Control
//   state_o      : current state encoding
//   illegal_o    : sticky illegal-opcode flag
//   retired_o    : completed-instruction count
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  multicycle_ctrl_if.master   imem,
  output logic                PCWrite_o,
  output logic                RegWrite_o,
  output logic                ALUSrc_o,
  output logic [ALUOP_W-1:0]  ALUOp_o,
  output logic [STATE_W-1:0]  state_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    retired_o
);

  state_t       state_q, state_d;
  alu_class_t   class_q, class_d;
  logic         illegal_q, illegal_d;
  logic         imem_req_q;
  logic         wb_q;
  logic         alu_src_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic         alu_phase_d;

  // Next-state and decode.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (imem.Op_i == OPC_R_TYPE) begin
          state_d = S_EXEC;
          class_d = CLASS_R;
        end else if (imem.Op_i == OPC_I_ALU) begin
          state_d = S_EXEC;
          class_d = CLASS_I;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d = start_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign alu_phase_d = (state_d == S_EXEC) || (state_d == S_WB);

  // State register; strobes are pre-decoded from the next state so they
  // come straight out of flops yet line up with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      class_q    <= CLASS_R;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b0;
      wb_q       <= 1'b0;
      alu_src_q  <= 1'b0;
      alu_op_q   <= ALUOP_NONE;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      illegal_q  <= illegal_d;
      imem_req_q <= (state_d == S_FETCH);
      wb_q       <= (state_d == S_WB);
      alu_src_q  <= alu_phase_d && (class_d == CLASS_I);
      alu_op_q   <= alu_phase_d ? alu_op_of(class_d) : ALUOP_NONE;
    end
  end

  // IRWrite is the one strobe allowed to follow imem_ready_i combinationally.
  assign imem.IRWrite_o  = (state_q == S_FETCH) && imem.imem_ready_i;
  assign imem.imem_req_o = imem_req_q;
  assign PCWrite_o       = wb_q;
  assign RegWrite_o      = wb_q;
  assign ALUSrc_o        = alu_src_q;
  assign ALUOp_o         = alu_op_q;
  assign state_o         = state_q;
  assign illegal_o       = illegal_q;

  // A retirement is counted at the edge leaving WB.
  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (state_q == S_WB),
    .count_o (retired_o)
  );

endmodule
